// File: rtl/rotation_amount_finder.sv
// Iterative inverse of the barrel rotator: finds the smallest left rotation k of A that equals B,
// testing one candidate per clock, and reports it in the rotator's amount/direction encoding.
module rotation_amount_finder #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               found,
  output logic [SHIFT_W-1:0] shift,
  output logic               L
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [SHIFT_W-1:0] K_MAX = SHIFT_W'(WIDTH - 1);
  localparam logic [SHIFT_W-1:0] HALF  = SHIFT_W'(WIDTH / 2);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_work;
  logic [WIDTH-1:0]     r_target;
  logic [SHIFT_W-1:0]   r_k;
  logic                 r_found;
  logic [SHIFT_W-1:0]   r_shift;
  logic                 r_l;
  logic                 w_match;
  logic [SHIFT_W-1:0]   w_negK;

  assign w_match = (r_work == r_target);
  // WIDTH-k in SHIFT_W bits is simply the two's complement of k
  assign w_negK  = '0 - r_k;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = SEARCH;
      SEARCH:  if (w_match || (r_k == K_MAX)) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_work   <= '0;
      r_target <= '0;
      r_k      <= '0;
      r_found  <= 1'b0;
      r_shift  <= '0;
      r_l      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work   <= A;
            r_target <= B;
            r_k      <= '0;
          end
        end
        SEARCH: begin
          if (w_match) begin
            r_found <= 1'b1;
            if (r_k == '0) begin
              r_shift <= '0;
              r_l     <= 1'b0;
            end else if (r_k <= HALF) begin
              r_shift <= r_k;
              r_l     <= 1'b1;
            end else begin
              r_shift <= w_negK;
              r_l     <= 1'b0;
            end
          end else begin
            r_work <= {r_work[WIDTH-2:0], r_work[WIDTH-1]};
            r_k    <= r_k + 1'b1;
            if (r_k == K_MAX) begin
              r_found <= 1'b0;
              r_shift <= '0;
              r_l     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign found     = r_found;
  assign shift     = r_shift;
  assign L         = r_l;

endmodule

// File: tb/tb_rotation_amount_finder.sv
// Self-checking bench for rotation_amount_finder: directed cases, backpressure, mid-search reset,
// and randomized requests compared against a brute-force rotation model.
module tb_rotation_amount_finder;

  localparam int WIDTH   = 32;
  localparam int SHIFT_W = $clog2(WIDTH);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               out_valid;
  logic               out_ready;
  logic               found;
  logic [SHIFT_W-1:0] shift;
  logic               L;

  int nAsserts = 0;
  int nFails   = 0;

  rotation_amount_finder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .found(found), .shift(shift), .L(L)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] a, input int k);
    logic [WIDTH-1:0] r;
    r = a;
    for (int i = 0; i < k; i++) r = {r[WIDTH-2:0], r[WIDTH-1]};
    return r;
  endfunction

  // Expected result and latency (edges after acceptance until out_valid) from the rotation rules
  task automatic refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic eFound, output int eShift, output logic eL, output int eLat);
    int k;
    k = -1;
    for (int i = WIDTH - 1; i >= 0; i--) if (rotl(a, i) == b) k = i;
    if (k < 0) begin
      eFound = 0; eShift = 0; eL = 0; eLat = WIDTH;
    end else begin
      eFound = 1; eLat = k + 1;
      if (k == 0)               begin eShift = 0;         eL = 0; end
      else if (k <= WIDTH / 2)  begin eShift = k;         eL = 1; end
      else                      begin eShift = WIDTH - k; eL = 0; end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid (bounded) after an accept edge, then checks latency and result
  task automatic checkOutput(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic eFound, eL;
    int eShift, eLat, cnt;
    refModel(a, b, eFound, eShift, eL, eLat);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      A = $urandom; B = $urandom;
    end while (!out_valid && cnt < WIDTH + 8);
    check("latency", cnt, eLat);
    check("found", found, eFound);
    check("shift", shift, eShift);
    check("L", L, eL);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    check("in_ready_before_req", in_ready, 1);
    in_valid = 1; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 0;
    checkOutput(a, b);
    if (out_ready) begin
      @(posedge clk); #1;
      check("out_valid_after_hs", out_valid, 0);
      check("in_ready_after_hs", in_ready, 1);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic sFound, sL;
    logic [SHIFT_W-1:0] sShift;

    rst_n = 0; in_valid = 0; out_ready = 1; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_found", found, 0);
    check("reset_shift", shift, 0);
    check("reset_L", L, 0);

    applyStimulus(32'h8000_0001, 32'h0000_0003);
    applyStimulus(32'h0000_0001, 32'h8000_0000);
    applyStimulus(32'h1234_5678, 32'h5678_1234);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(32'hAAAA_AAAA, 32'h5555_5555);
    applyStimulus(32'h0000_0001, 32'h0000_0003);
    applyStimulus(32'h0000_00F0, 32'h0F00_0000);

    // Backpressure: result must hold while the consumer stalls and new requests are ignored
    out_ready = 0;
    in_valid = 1; A = 32'h0000_0010; B = 32'h0000_0100;
    @(posedge clk); #1;
    in_valid = 0;
    checkOutput(32'h0000_0010, 32'h0000_0100);
    sFound = found; sShift = shift; sL = L;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0) || (i == 4);
      A = (i == 4) ? 32'h0000_0003 : $urandom;
      B = (i == 4) ? 32'hC000_0000 : $urandom;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_found", found, sFound);
      check("bp_shift", shift, sShift);
      check("bp_L", L, sL);
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_out_valid_after_hs", out_valid, 0);
    check("bp_in_ready_after_hs", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    checkOutput(32'h0000_0003, 32'hC000_0000);
    @(posedge clk); #1;
    check("bp2_in_ready", in_ready, 1);

    // Reset in the middle of a search
    in_valid = 1; A = 32'h0000_0001; B = 32'h8000_0000;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_found", found, 0);
    check("midrst_shift", shift, 0);
    check("midrst_L", L, 0);
    rst_n = 1;
    check("midrst_in_ready", in_ready, 1);
    applyStimulus(32'hDEAD_BEEF, rotl(32'hDEAD_BEEF, 20));

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      if (n % 3 == 0) ra = {8{ra[3:0]}};
      rb = (n % 2 == 0) ? rotl(ra, $urandom_range(0, WIDTH - 1)) : $urandom;
      applyStimulus(ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
